// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester/response bundle between DSP clients and the shared multiplier
interface mul_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  logic busy;
  logic [15:0] ops_count;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_id, busy, ops_count
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy, ops_count
  );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one 16x16 signed Baugh-Wooley multiplier,
// two register stages with valid/ready backpressure and ID-tagged responses
module mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst_n,
  mul_share_arb_if.slave bus
);
  logic r_v1;
  logic [15:0] r_a, r_b;
  logic [IDW-1:0] r_id, r_ptr;
  logic r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [IDW-1:0] r_rsp_id;
  logic [15:0] r_ops;
  logic w_s2_adv, w_s1_adv, w_any, w_acc;
  logic [IDW-1:0] w_gid, w_idx;
  logic [31:0] w_prod;
  assign w_s2_adv = !r_rsp_valid | bus.rsp_ready;
  assign w_s1_adv = !r_v1 | w_s2_adv;
  assign w_any = |bus.req_valid;
  assign w_acc = w_any & w_s1_adv;
  assign bus.req_ready = w_acc ? (NUM_REQ'(1) << w_gid) : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_id = r_rsp_id;
  assign bus.busy = r_v1 | r_rsp_valid;
  assign bus.ops_count = r_ops;
  // scan from farthest to nearest so the closest requester after ptr wins
  always_comb begin
    w_gid = '0;
    w_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (bus.req_valid[w_idx]) w_gid = w_idx;
    end
  end
  // Baugh-Wooley: sign-row/column partial products inverted, plus 2^16 and 2^31 corrections
  always_comb begin
    w_prod = 32'h8001_0000;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        w_prod = w_prod + (32'(r_a[i] & r_b[j] ^ ((i == 15) != (j == 15))) << (i + j));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_id <= '0;
      r_ptr <= IDW'(NUM_REQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_id <= '0;
      r_ops <= '0;
    end else begin
      if (w_s1_adv) r_v1 <= w_acc;
      if (w_acc) begin
        r_a <= bus.req_a[{w_gid, 4'd0} +: 16];
        r_b <= bus.req_b[{w_gid, 4'd0} +: 16];
        r_id <= w_gid;
        r_ptr <= w_gid;
      end
      if (w_s2_adv) r_rsp_valid <= r_v1;
      if (w_s2_adv && r_v1) begin
        r_rsp_data <= w_prod;
        r_rsp_id <= r_id;
      end
      if (r_rsp_valid && bus.rsp_ready) r_ops <= r_ops + 16'd1;
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed table vectors plus hand-written sequences for
// round-robin, backpressure, mid-flight reset and counter wrap
module tb_mul_share_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mul_share_arb_if #(.NUM_REQ(4), .IDW(2)) bus ();
  mul_share_arb #(.NUM_REQ(4), .IDW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int id;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs [8];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask
  initial begin
    vecs[0] = '{0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[1] = '{1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[2] = '{2, 16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[3] = '{3, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[4] = '{0, 16'h0000, 16'hFFFB, 32'h00000000};
    vecs[5] = '{1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1};
    vecs[6] = '{2, 16'h1234, 16'h0010, 32'h00012340};
    vecs[7] = '{3, 16'hFF00, 16'hFF00, 32'h00010000};
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    tick;
    tick;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ops_count", 32'(bus.ops_count), 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_req_ready", 32'(bus.req_ready), 32'd0);
    // table vectors: one op at a time, exact two-cycle latency
    for (int n = 0; n < 8; n++) begin
      set_op(vecs[n].id, vecs[n].a, vecs[n].b);
      bus.req_valid = 4'(1 << vecs[n].id);
      #1;
      check($sformatf("vec%0d_req_ready", n), 32'(bus.req_ready), 32'(1 << vecs[n].id));
      tick;
      bus.req_valid = '0;
      #1;
      check($sformatf("vec%0d_latency", n), 32'(bus.rsp_valid), 32'd0);
      tick;
      check($sformatf("vec%0d_rsp_valid", n), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("vec%0d_rsp_data", n), bus.rsp_data, vecs[n].p);
      check($sformatf("vec%0d_rsp_id", n), 32'(bus.rsp_id), 32'(vecs[n].id));
      tick;
      check($sformatf("vec%0d_ops_count", n), 32'(bus.ops_count), 32'(n + 1));
    end
    // round-robin fairness with all four requesters asserting
    do_reset;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 2), 16'h0100);
    bus.req_valid = 4'hF;
    #1;
    for (int t = 0; t < 10; t++) begin
      if (t < 8) check($sformatf("rr%0d_grant", t), 32'(bus.req_ready), 32'(1 << (t % 4)));
      if (t >= 2) begin
        check($sformatf("rr%0d_rsp_valid", t), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("rr%0d_rsp_id", t), 32'(bus.rsp_id), 32'((t - 2) % 4));
        check($sformatf("rr%0d_rsp_data", t), bus.rsp_data, 32'((((t - 2) % 4) + 2) * 256));
      end
      tick;
      if (t == 7) bus.req_valid = '0;
      #1;
    end
    check("rr_ops_count", 32'(bus.ops_count), 32'd8);
    check("rr_drained", 32'(bus.busy), 32'd0);
    // backpressure: three accepts, then five stalled cycles
    do_reset;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 10), 16'hFFFE);
    bus.req_valid = 4'hF;
    #1;
    check("bp_grant0", 32'(bus.req_ready), 32'h1);
    tick;
    check("bp_grant1", 32'(bus.req_ready), 32'h2);
    tick;
    check("bp_grant2", 32'(bus.req_ready), 32'h4);
    check("bp_rsp0_id", 32'(bus.rsp_id), 32'd0);
    check("bp_rsp0_data", bus.rsp_data, 32'hFFFFFFEC);
    tick;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'h8;
    for (int s = 0; s < 5; s++) begin
      #1;
      check($sformatf("bp_stall%0d_ready", s), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp_stall%0d_valid", s), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_stall%0d_id", s), 32'(bus.rsp_id), 32'd1);
      check($sformatf("bp_stall%0d_data", s), bus.rsp_data, 32'hFFFFFFEA);
      tick;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    #1;
    check("bp_rel_id1", 32'(bus.rsp_id), 32'd1);
    tick;
    check("bp_rel_valid2", 32'(bus.rsp_valid), 32'd1);
    check("bp_rel_id2", 32'(bus.rsp_id), 32'd2);
    check("bp_rel_data2", bus.rsp_data, 32'hFFFFFFE8);
    tick;
    check("bp_rel_empty", 32'(bus.rsp_valid), 32'd0);
    check("bp_ops_count", 32'(bus.ops_count), 32'd3);
    // mid-flight reset discards both in-flight ops and the pointer
    do_reset;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'h0003);
    bus.req_valid = 4'h3;
    tick;
    tick;
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ops_count", 32'(bus.ops_count), 32'd0);
    bus.req_valid = 4'hF;
    #1;
    check("rst_first_grant", 32'(bus.req_ready), 32'h1);
    tick;
    bus.req_valid = '0;
    #1;
    check("rst_no_stale", 32'(bus.rsp_valid), 32'd0);
    tick;
    check("rst_new_id", 32'(bus.rsp_id), 32'd0);
    check("rst_new_data", bus.rsp_data, 32'd3);
    // counter wrap: continuous accepts from requester 0
    do_reset;
    set_op(0, 16'h0001, 16'h0001);
    bus.req_valid = 4'h1;
    for (int k = 0; k < 65537; k++) tick;
    check("wrap_ffff", 32'(bus.ops_count), 32'h0000FFFF);
    tick;
    check("wrap_0000", 32'(bus.ops_count), 32'h00000000);
    tick;
    check("wrap_0001", 32'(bus.ops_count), 32'h00000001);
    bus.req_valid = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one combinational 16x16 signed Baugh-Wooley multiplier instance between NUM_REQ independent requesters.
- Arbitrates requests round-robin and registers the selected operands (stage 1) and the product (stage 2).
- Returns each result on a single response channel with valid/ready backpressure, tagged with the requester ID.
- Sits between the DSP-side clients and the multiplier datapath; sustains 1 product per cycle when the response side is not stalled.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- req_a  in  NUM_REQ*16  signed multiplicand; requester i occupies bits [16i+15:16i].
- req_b  in  NUM_REQ*16  signed multiplier, same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  32  signed product a*b, two's complement.
- rsp_id  out  IDW  index of the requester that issued this result.
- busy  out  1  high when any operation is in flight (v1 | rsp_valid).
- ops_count  out  16  count of completed response handshakes; wraps modulo 2^16.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - v1, rsp_valid, and busy go to 0.
  - rsp_data, rsp_id, ops_count, and stage-1 operand/ID registers go to 0.
  - RR pointer goes to NUM_REQ-1, so requester 0 has first priority.
- Pipeline control:
  - s2_adv = !rsp_valid | rsp_ready.
  - s1_adv = !v1 | s2_adv.
- Arbitration:
  - Among set req_valid bits, grant the first index found searching upward (with wrap) from ptr+1.
  - Exactly one grant or none.
  - req_ready[i] = grant[i] & s1_adv.
  - Only the granted requester sees ready.
- Accept: when req_valid[g] & req_ready[g]:
  - Stage-1 registers load req_a/req_b slice g and ID g.
  - v1 is set to 1.
  - ptr is set to g.
  - The pointer never moves without an accept, including while stalled.
- Stage 1 with no accept but s1_adv=1: v1 clears to 0.
- Stage 2 when s2_adv=1:
  - rsp_valid <= v1.
  - If v1=1, rsp_data <= product of the stage-1 operands and rsp_id <= stage-1 ID.
- Stall hold: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id are held stable.
  - If v1=1, stage 1 also holds and all req_ready are 0.
  - If v1=0, one more request may be accepted into stage 1 (2-entry skid).
- Latency: a request accepted in cycle C has rsp_valid=1 in cycle C+2 when unstalled.
- Throughput: back-to-back accepts every cycle while rsp_ready=1.
- Results leave strictly in acceptance order.
- ops_count increments by 1 on each cycle where rsp_valid & rsp_ready; 0xFFFF wraps to 0x0000.
- Arithmetic: full 32-bit signed product, no saturation.
  - -32768 * -32768 = 0x40000000.
- Simultaneous events: in the same cycle, an accept into stage 1 and a stage 1 -> stage 2 move both occur; no bubble is inserted.
- Reset mid-operation: in-flight operations are discarded, no response is issued for them, and the pointer is reset.
- Requester obligation: hold req_valid, req_a, and req_b stable until accepted. The block does not depend on this for correctness.

Test Plan:
- Single op: req0 a=0x7FFF, b=0x7FFF, rsp_ready=1 -> rsp_valid in accept cycle+2, rsp_data=0x3FFF0001, rsp_id=0, ops_count=1.
- Signed corners: (-32768)*(-32768) -> 0x40000000; (-32768)*32767 -> 0xC0008000; (-1)*1 -> 0xFFFFFFFF; 0*(-5) -> 0x00000000.
- Round-robin fairness: all 4 requesters hold req_valid for 8 accepts -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence matches; no requester starves.
- Backpressure: 3 back-to-back accepts, then rsp_ready=0 for 5 cycles -> rsp_data/rsp_id held; exactly 2 ops buffered, req_ready=0; on release, results arrive in order with no loss or duplication.
- Reset mid-flight: accept 2 ops, assert rst_n=0 for 1 cycle -> rsp_valid=0, busy=0, ops_count=0; next grant goes to requester 0; no stale response.
- Counter wrap: preload via 65536 accepts with rsp_ready=1 -> ops_count returns to 0x0000 and continues to 0x0001.
